// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates the condition field against the stored
// {Zero, Neg} flags and gates the control requests. Define COND_SKIP_COUNT_EN to build the squash counter.
module cond_unit #(
    parameter logic [1:0]  FLAG_RST = 2'b00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic [3:0]       cond_i,
    input  logic             flag_write_i,
    input  logic [1:0]       alu_flags_i,
    input  logic             reg_write_i,
    input  logic             mem_write_i,
    input  logic             pc_src_i,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic             pc_src_o,
    output logic             cond_ex_o,
    output logic [1:0]       flags_o,
    output logic [CNT_W-1:0] skip_cnt_o
);

    logic [1:0] flags_q;
    logic       zero;
    logic       neg;
    logic       cond_pass;
    logic       flag_upd;

    assign zero = flags_q[1];
    assign neg  = flags_q[0];

    // Condition decode uses the stored flags only; same-cycle ALU flags are never bypassed.
    always_comb begin
        cond_pass = 1'b0;
        case (cond_i)
            4'b0000: cond_pass = zero;
            4'b0001: cond_pass = ~zero;
            4'b0100: cond_pass = neg;
            4'b0101: cond_pass = ~neg;
            4'b1010: cond_pass = ~neg;
            4'b1011: cond_pass = neg;
            4'b1100: cond_pass = ~zero & ~neg;
            4'b1101: cond_pass = zero | neg;
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign cond_ex_o   = valid_i & cond_pass;
    assign reg_write_o = reg_write_i & cond_ex_o;
    assign mem_write_o = mem_write_i & cond_ex_o;
    assign pc_src_o    = pc_src_i & cond_ex_o;

    assign flag_upd = cond_ex_o & flag_write_i & ~stall_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= FLAG_RST;
        end else if (flag_upd) begin
            flags_q <= alu_flags_i;
        end
    end

    assign flags_o = flags_q;

`ifdef COND_SKIP_COUNT_EN
    logic [CNT_W-1:0] skip_q;
    logic             squash;

    assign squash = valid_i & ~cond_ex_o & ~stall_i;

    // Free-running squash count; wraps silently at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            skip_q <= '0;
        end else if (squash) begin
            skip_q <= skip_q + CNT_W'(1);
        end
    end

    assign skip_cnt_o = skip_q;
`else
    assign skip_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed literal checks plus randomized traffic against a
// behavioural flag/squash model compared on every falling edge.
module tb_cond_unit;

    localparam logic [1:0]  FLAG_RST = 2'b01;
    localparam int unsigned CNT_W    = 4;
`ifdef COND_SKIP_COUNT_EN
    localparam bit SKIP_ON = 1'b1;
`else
    localparam bit SKIP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             valid_i = 1'b0;
    logic             stall_i = 1'b0;
    logic [3:0]       cond_i = 4'h0;
    logic             flag_write_i = 1'b0;
    logic [1:0]       alu_flags_i = 2'b00;
    logic             reg_write_i = 1'b0;
    logic             mem_write_i = 1'b0;
    logic             pc_src_i = 1'b0;
    logic             reg_write_o;
    logic             mem_write_o;
    logic             pc_src_o;
    logic             cond_ex_o;
    logic [1:0]       flags_o;
    logic [CNT_W-1:0] skip_cnt_o;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    cond_unit #(.FLAG_RST(FLAG_RST), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i),
        .cond_i(cond_i), .flag_write_i(flag_write_i), .alu_flags_i(alu_flags_i),
        .reg_write_i(reg_write_i), .mem_write_i(mem_write_i), .pc_src_i(pc_src_i),
        .reg_write_o(reg_write_o), .mem_write_o(mem_write_o), .pc_src_o(pc_src_o),
        .cond_ex_o(cond_ex_o), .flags_o(flags_o), .skip_cnt_o(skip_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference: condition truth from the mnemonic rules, state as plain integers.
    function automatic bit cond_true(input logic [3:0] c, input logic [1:0] f);
        bit z = f[1];
        bit n = f[0];
        if (c == 4'd0)  return z;            // EQ
        if (c == 4'd1)  return !z;           // NE
        if (c == 4'd4)  return n;            // MI
        if (c == 4'd5)  return !n;           // PL
        if (c == 4'd10) return !n;           // GE
        if (c == 4'd11) return n;            // LT
        if (c == 4'd12) return !z && !n;     // GT
        if (c == 4'd13) return z || n;       // LE
        if (c == 4'd14) return 1'b1;         // AL
        return 1'b0;
    endfunction

    logic [1:0] flags_m = FLAG_RST;
    int         skips_m = 0;

    always @(posedge clk) begin
        if (!reset) begin
            flags_m = FLAG_RST;
            skips_m = 0;
        end else if (valid_i && !stall_i) begin
            if (cond_true(cond_i, flags_m)) begin
                if (flag_write_i) flags_m = alu_flags_i;
            end else begin
                skips_m = skips_m + 1;
            end
        end
    end

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Every falling edge: outputs against the model.
    always @(negedge clk) begin
        if (run) begin
            bit ex;
            ex = valid_i && cond_true(cond_i, flags_m);
            cmp("m_cond_ex", 16'(cond_ex_o), 16'(ex));
            cmp("m_reg_write", 16'(reg_write_o), 16'(ex && reg_write_i));
            cmp("m_mem_write", 16'(mem_write_o), 16'(ex && mem_write_i));
            cmp("m_pc_src", 16'(pc_src_o), 16'(ex && pc_src_i));
            cmp("m_flags", 16'(flags_o), 16'(flags_m));
            cmp("m_skip_cnt", 16'(skip_cnt_o), SKIP_ON ? 16'(skips_m % 16) : 16'd0);
        end
    end

    task automatic drive(input logic v, input logic s, input logic [3:0] c, input logic fw,
                         input logic [1:0] af, input logic rw, input logic mw, input logic ps,
                         input logic rst);
        @(posedge clk);
        #1;
        valid_i = v; stall_i = s; cond_i = c; flag_write_i = fw; alu_flags_i = af;
        reg_write_i = rw; mem_write_i = mw; pc_src_i = ps; reset = rst;
    endtask

    initial begin
        // Reset
        drive(0, 1, 4'hE, 1, 2'b11, 0, 0, 0, 0);
        drive(0, 0, 4'hE, 0, 2'b00, 0, 0, 0, 0);
        run = 1'b1;
        @(negedge clk);
        cmp("rst_flags", 16'(flags_o), 16'(FLAG_RST));
        cmp("rst_skip", 16'(skip_cnt_o), 16'd0);

        // AL write of 10, then EQ sees Z
        drive(1, 0, 4'hE, 1, 2'b10, 0, 0, 0, 1);
        @(negedge clk);
        cmp("al_cond_ex", 16'(cond_ex_o), 16'd1);
        drive(1, 0, 4'h0, 0, 2'b00, 1, 0, 0, 1);
        @(negedge clk);
        cmp("al_flags", 16'(flags_o), 16'b10);
        cmp("eq_reg_write", 16'(reg_write_o), 16'd1);

        // GT fails with N set
        drive(1, 0, 4'hE, 1, 2'b01, 0, 0, 0, 1);
        drive(1, 0, 4'hC, 0, 2'b00, 0, 1, 1, 1);
        @(negedge clk);
        cmp("gt_flags", 16'(flags_o), 16'b01);
        cmp("gt_cond_ex", 16'(cond_ex_o), 16'd0);
        cmp("gt_mem_write", 16'(mem_write_o), 16'd0);
        cmp("gt_pc_src", 16'(pc_src_o), 16'd0);

        // Stalled flag write holds, released write lands
        drive(1, 0, 4'hE, 1, 2'b00, 0, 0, 0, 1);
        @(negedge clk);
        cmp("gt_skip", 16'(skip_cnt_o), SKIP_ON ? 16'd1 : 16'd0);
        drive(1, 1, 4'h1, 1, 2'b11, 0, 0, 0, 1);
        @(negedge clk);
        cmp("ne_pre_flags", 16'(flags_o), 16'b00);
        drive(1, 0, 4'h1, 1, 2'b11, 0, 0, 0, 1);
        @(negedge clk);
        cmp("ne_stall_flags", 16'(flags_o), 16'b00);
        drive(0, 0, 4'hE, 0, 2'b00, 0, 0, 0, 1);
        @(negedge clk);
        cmp("ne_flags", 16'(flags_o), 16'b11);

        // Undefined codes and invalid AL
        drive(1, 0, 4'hF, 0, 2'b00, 1, 1, 1, 1);
        @(negedge clk);
        cmp("c1111_cond_ex", 16'(cond_ex_o), 16'd0);
        drive(1, 0, 4'h3, 0, 2'b00, 1, 1, 1, 1);
        @(negedge clk);
        cmp("c0011_cond_ex", 16'(cond_ex_o), 16'd0);
        drive(0, 0, 4'hE, 0, 2'b00, 1, 1, 1, 1);
        @(negedge clk);
        cmp("inv_al_cond_ex", 16'(cond_ex_o), 16'd0);
        cmp("inv_al_reg_write", 16'(reg_write_o), 16'd0);

        // Counter wrap at CNT_W=4
        drive(0, 0, 4'hE, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) drive(1, 0, 4'hF, 0, 2'b00, 0, 0, 0, 1);
        @(negedge clk);
        cmp("skip_full", 16'(skip_cnt_o), SKIP_ON ? 16'd15 : 16'd0);
        drive(0, 0, 4'hE, 0, 2'b00, 0, 0, 0, 1);
        @(negedge clk);
        cmp("skip_wrap", 16'(skip_cnt_o), 16'd0);

        // Reset overrides a passing flag write
        drive(1, 0, 4'hE, 1, 2'b10, 0, 0, 0, 1);
        drive(1, 0, 4'hF, 0, 2'b00, 0, 0, 0, 1);
        drive(1, 0, 4'hE, 1, 2'b11, 1, 0, 0, 0);
        @(negedge clk);
        cmp("rstw_reg_write", 16'(reg_write_o), 16'd1);
        drive(0, 0, 4'hE, 0, 2'b00, 0, 0, 0, 1);
        @(negedge clk);
        cmp("rstw_flags", 16'(flags_o), 16'(FLAG_RST));
        cmp("rstw_skip", 16'(skip_cnt_o), 16'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(3, 0) != 0), ($urandom_range(3, 0) == 0),
                  4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                  2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  ($urandom_range(59, 0) != 0));
        end
        @(negedge clk);
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter FLAG_RST, default 2'b00, the reset value of the flag register as {Zero, Neg}.
REQ-002 SHALL have parameter CNT_W, default 16, the skip counter width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 valid_i  input  1  an execute-stage instruction is present.
REQ-006 stall_i  input  1  the pipeline is held; no state update this cycle.
REQ-007 cond_i  input  4  condition field of the instruction.
REQ-008 flag_write_i  input  1  the instruction requests a flag update.
REQ-009 alu_flags_i  input  2  {Zero, Neg} from the ALU in the current cycle.
REQ-010 reg_write_i, mem_write_i, pc_src_i  input  1 each  unconditioned control requests.
REQ-011 reg_write_o, mem_write_o, pc_src_o  output  1 each  gated control.
REQ-012 cond_ex_o  output  1  the condition passed for a valid instruction.
REQ-013 flags_o  output  2  registered {Zero, Neg}.
REQ-014 skip_cnt_o  output  CNT_W  count of squashed instructions.

Function
REQ-015 Condition evaluation SHALL be combinational against flags_o (Z=flags_o[1], N=flags_o[0]), not against alu_flags_i.
REQ-016 Condition code map SHALL be: 0000 EQ Z; 0001 NE !Z; 0100 MI N; 0101 PL !N; 1010 GE !N; 1011 LT N; 1100 GT !Z&!N; 1101 LE Z|N; 1110 AL 1.
REQ-017 All other codes (0010, 0011, 0110-1001, 1111) SHALL evaluate false.
REQ-018 cond_ex_o SHALL equal valid_i AND condition result.
REQ-019 Each gated output SHALL equal its request input AND cond_ex_o, with zero-cycle latency.
REQ-020 Gated outputs SHALL NOT depend on stall_i.
REQ-021 Flag update condition: valid_i & cond_ex_o & flag_write_i & !stall_i.
REQ-022 When the flag update condition holds, flags_o SHALL take alu_flags_i at the next edge; otherwise flags_o SHALL hold.
REQ-023 A flag write SHALL be visible to the next instruction's condition one cycle later; same-cycle flags are never used.
REQ-024 An instruction whose condition fails SHALL NOT update flags, even when flag_write_i=1.
REQ-025 Squash condition: valid_i & !cond_ex_o & !stall_i; on it, skip_cnt SHALL increment by 1 at the next edge.
REQ-026 skip_cnt SHALL wrap from all-ones to 0 with no saturation and no flag.
REQ-027 Under stall_i=1, the flag register and skip_cnt SHALL hold regardless of other inputs.
REQ-028 With valid_i=0, all gated outputs and cond_ex_o SHALL be 0 and no state SHALL change.

Reset
REQ-029 While reset=0 at an edge, flags_o SHALL load FLAG_RST and skip_cnt SHALL load 0, overriding stall_i and any flag write.
REQ-030 Gated outputs SHALL remain combinational during reset and follow REQ-018/019 using the current flags_o.
REQ-031 Reset asserted mid-sequence SHALL discard any pending flag update of that cycle.

Configuration
REQ-032 Macro COND_SKIP_COUNT_EN SHALL compile the skip counter in or out.
REQ-033 With COND_SKIP_COUNT_EN defined, skip_cnt_o SHALL present the counter per REQ-025/026/029.
REQ-034 Without COND_SKIP_COUNT_EN, the port SHALL remain, skip_cnt_o SHALL be constant 0, and no counter flops SHALL be inferred.

Verification
REQ-035 Reset, then AL with flag_write_i=1, alu_flags_i=2'b10 -> flags_o=2'b10 next cycle; following EQ with reg_write_i=1 -> reg_write_o=1.
REQ-036 flags_o=2'b01, cond_i=GT, mem_write_i=1, pc_src_i=1 -> all gated outputs 0, cond_ex_o=0; skip_cnt_o +1 when the macro is defined.
REQ-037 flags_o=2'b00, cond_i=NE, flag_write_i=1, alu_flags_i=2'b11, stall_i=1 -> flags_o stays 00; with stall_i=0 next cycle -> 11.
REQ-038 cond_i=1111 and cond_i=0011 at any flags -> cond_ex_o=0; cond_i=1110 with valid_i=0 -> cond_ex_o=0.
REQ-039 Preload skip_cnt_o to all-ones via repeated squashes with CNT_W=4 (15 squashes), one more squash -> skip_cnt_o=0.
REQ-040 reset=0 in the same cycle as a passing flag write of 2'b11 -> flags_o=FLAG_RST and skip_cnt_o=0 next cycle.
